// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the five-stage RV32 core.
//   * Execute-stage operand forwarding selects (M result beats W result).
//   * Load-use detection: one bubble into E while F and D hold.
//   * Memory-wait FSM (RUN / MEM_WAIT). It holds F, D, E and M while a
//     memory-stage access waits for mem_ready. The wait is bounded by
//     MEM_TIMEOUT cycles and raises a sticky mem_timeout flag when the
//     bound forces the release.
//   * Optional performance counters, built only when the macro
//     HAZARD_PERF_CNT_EN is defined. Otherwise both outputs read 0 and no
//     counter flops exist.
//
// Parameters
//   MEM_TIMEOUT  wait-cycle bound before forced release (1 .. 2**CNT_W-1)
//   CNT_W        width of the wait counter
//
// Ports
//   clk, reset                 core clock, asynchronous active-low reset
//   rs1D, rs2D                 decode-stage source registers
//   rs1E, rs2E, rdE            execute-stage sources / destination
//   result_srcE                execute result select (2'b01 = load)
//   pc_srcE                    branch/jump taken in execute
//   rdM, rdW                   memory / writeback destinations
//   reg_writeM, reg_writeW     register-file write enables
//   mem_reqM                   data access in progress in M
//   mem_ready                  data memory completes the access this cycle
//   StallF/D/E/M               hold the respective pipeline register
//   FlushD, FlushE             clear the respective pipeline register
//   ForwardAE, ForwardBE       00 = regfile, 01 = W result, 10 = M ALU result
//   mem_timeout                sticky: a wait ran into MEM_TIMEOUT
//   stall_cycles, flush_count  32-bit wrapping performance counters
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic [1:0]  result_srcE,
  input  logic        pc_srcE,
  input  logic [4:0]  rdM,
  input  logic [4:0]  rdW,
  input  logic        reg_writeM,
  input  logic        reg_writeW,
  input  logic        mem_reqM,
  input  logic        mem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             at_limit;
  logic             timeout_set;
  logic             lw_stall;
  logic             mem_stall;

  // ---------------------------------------------------------------------------
  // Forwarding: the M-stage producer is younger, so it wins over W.
  // x0 is never forwarded because it always reads as zero.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(rs1E, rdM, reg_writeM, rdW, reg_writeW);
  assign ForwardBE = fwd_sel(rs2E, rdM, reg_writeM, rdW, reg_writeW);

  // ---------------------------------------------------------------------------
  // Hazard detection and pipeline controls
  // ---------------------------------------------------------------------------
  assign lw_stall = (result_srcE == 2'b01) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  // The cycle in which the counter reaches the bound is let through, so a
  // dead memory cannot hold the core forever.
  assign at_limit  = (state == ST_MEM_WAIT) && (cnt == TIMEOUT_VAL);
  assign mem_stall = mem_reqM && !mem_ready && !at_limit;

  // A memory stall freezes E, which keeps pc_srcE stable, so any pending
  // flush is simply deferred to the release cycle.
  assign StallF = lw_stall | mem_stall;
  assign StallD = lw_stall | mem_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  assign FlushD = pc_srcE & ~mem_stall;
  assign FlushE = (lw_stall | pc_srcE) & ~mem_stall;

  // ---------------------------------------------------------------------------
  // Memory-wait FSM: next state and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    timeout_set = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_reqM && !mem_ready) begin
          state_n = ST_MEM_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready || at_limit) begin
          state_n = ST_RUN;
          cnt_n   = '0;
          // A ready arriving on the limit cycle is a normal completion.
          timeout_set = at_limit && !mem_ready;
        end else begin
          // One count per wait cycle, so MEM_TIMEOUT bounds the stall in
          // cycles.
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_n;
      cnt   <= cnt_n;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2**32)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (StallF)          stall_cycles <= stall_cycles + 32'd1;
      if (FlushD | FlushE) flush_count  <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
